// File: rtl/stream_qos_scheduler_if.sv
// stream_qos_scheduler_if
//   Bundles the STREAM_COUNT source-side stream ports and the single
//   sink-side stream port of the QoS scheduler.
//
//   Source side (one lane per input stream):
//     s_data_i[]  beat data          s_qos_i[]   per-stream QoS
//     s_last_i    last beat flags    s_valid_i   beat valid flags
//     s_ready_o   beat accepted flags
//   Sink side (the shared output stream):
//     m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o, m_ready_i
//
//   modport slave  : the scheduler itself
//   modport master : the environment (sources + downstream consumer)
interface stream_qos_scheduler_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
);
    logic [T_DATA_WIDTH-1:0] s_data_i [STREAM_COUNT];
    logic [T_QOS__WIDTH-1:0] s_qos_i  [STREAM_COUNT];
    logic [STREAM_COUNT-1:0] s_last_i;
    logic [STREAM_COUNT-1:0] s_valid_i;
    logic [STREAM_COUNT-1:0] s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic [T_QOS__WIDTH-1:0] m_qos_o;
    logic [T_ID___WIDTH-1:0] m_id_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_qos_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_qos_o, m_id_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_qos_scheduler.sv
// stream_qos_scheduler
//   Packet-locked QoS scheduler sharing one output stream among
//   STREAM_COUNT input streams. In IDLE it arbitrates among valid
//   streams (promoted first, then highest QoS, ties round-robin from
//   rr_ptr+1), latches the winner id and its QoS, and moves to BUSY.
//   In BUSY the granted stream is passed straight through to the output
//   until its last beat transfers; the FSM then spends one cycle in IDLE.
//
//   Optional feature macro: STREAM_QOS_SCHEDULER_AGING_EN
//     defined   : per-stream age counters; a stream that has lost
//                 AGE_LIMIT arbitrations while requesting is promoted
//     undefined : pure QoS + round-robin, AGE_LIMIT unused
//
//   Ports:
//     clk  clock
//     rst  asynchronous active-high reset
//     bus  stream_qos_scheduler_if.slave (source lanes + output stream)
module stream_qos_scheduler #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int AGE_LIMIT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_qos_scheduler_if.slave bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] id_q;
    logic [T_ID___WIDTH-1:0] rr_q;
    logic [T_QOS__WIDTH-1:0] qos_q;
    logic [T_ID___WIDTH-1:0] win_id;
    logic [STREAM_COUNT-1:0] promo;
    logic [STREAM_COUNT-1:0] elig;
    logic [T_QOS__WIDTH-1:0] max_qos;
    logic                    grant;
    logic                    xfer;

    // ------------------------------------------------------------------
    // Arbiter: build the eligible set (promoted streams if any, else the
    // valid streams at the maximum QoS), then take the first eligible
    // stream walking from rr_ptr+1 with wrap.
    // ------------------------------------------------------------------
    always_comb begin
        int  cand;
        logic hit;
        max_qos = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (bus.s_valid_i[i] && (bus.s_qos_i[i] > max_qos))
                max_qos = bus.s_qos_i[i];
        end
        for (int i = 0; i < STREAM_COUNT; i++) begin
            elig[i] = (|promo) ? promo[i]
                               : (bus.s_valid_i[i] && (bus.s_qos_i[i] == max_qos));
        end
        win_id = '0;
        hit    = 1'b0;
        cand   = 0;
        for (int k = 1; k <= STREAM_COUNT; k++) begin
            cand = (int'(rr_q) + k) % STREAM_COUNT;
            if (!hit && elig[cand[T_ID___WIDTH-1:0]]) begin
                hit    = 1'b1;
                win_id = cand[T_ID___WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Aging: counters only move on a grant, so they are frozen in BUSY.
    // ------------------------------------------------------------------
`ifdef STREAM_QOS_SCHEDULER_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);

    for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_age
        logic [AGE_W-1:0] age_q;

        assign promo[g] = bus.s_valid_i[g] && (age_q == AGE_W'(AGE_LIMIT));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                age_q <= '0;
            end else if (grant) begin
                if (win_id == T_ID___WIDTH'(g))
                    age_q <= '0;
                else if (bus.s_valid_i[g] && (age_q != AGE_W'(AGE_LIMIT)))
                    age_q <= age_q + 1'b1;
            end
        end
    end
`else
    localparam int unused_age_limit = AGE_LIMIT;
    assign promo = '0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign xfer = (state_q == BUSY) && bus.s_valid_i[id_q] && bus.m_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            qos_q   <= '0;
            // Start just before stream 0 so it wins the first tie.
            rr_q    <= T_ID___WIDTH'(STREAM_COUNT - 1);
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q  <= win_id;
                qos_q <= bus.s_qos_i[win_id];
                rr_q  <= win_id;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.s_valid_i) begin
                    grant   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Packet lock: only the locked stream's last beat releases us.
                if (xfer && bus.s_last_i[id_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux: zero-latency pass-through of the locked stream in BUSY,
    // all zeros in IDLE (and therefore immediately on reset).
    // ------------------------------------------------------------------
    always_comb begin
        bus.m_valid_o = 1'b0;
        bus.m_data_o  = '0;
        bus.m_last_o  = 1'b0;
        bus.s_ready_o = '0;
        if (state_q == BUSY) begin
            bus.m_valid_o       = bus.s_valid_i[id_q];
            bus.m_data_o        = bus.s_data_i[id_q];
            bus.m_last_o        = bus.s_last_i[id_q];
            bus.s_ready_o[id_q] = bus.m_ready_i;
        end
    end

    assign bus.m_id_o  = id_q;
    assign bus.m_qos_o = qos_q;

endmodule

// File: tb/tb_stream_qos_scheduler.sv
module tb_stream_qos_scheduler;

    localparam int DW  = 8;
    localparam int QW  = 4;
    localparam int N   = 3;
    localparam int IW  = 2;
    localparam int AGE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    stream_qos_scheduler_if #(
        .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N), .T_ID___WIDTH(IW)
    ) bus ();

    stream_qos_scheduler #(
        .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N), .T_ID___WIDTH(IW),
        .AGE_LIMIT(AGE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (packet-level view) ----------------
    bit mb;
    int mid, mqos, mrr;
    int mage [N];

    task automatic mdl_reset();
        mb = 0; mid = 0; mqos = 0; mrr = N - 1;
        for (int i = 0; i < N; i++) mage[i] = 0;
    endtask

    // Winner = among the candidate set, the stream closest after rr.
    function automatic int mdl_pick();
        int  maxq  = -1;
        bit  prom  = 0;
        int  best  = 0;
        int  bestd = N;
        int  d;
        bit  ok;
        for (int i = 0; i < N; i++) begin
            if (bus.s_valid_i[i]) begin
                if (int'(bus.s_qos_i[i]) > maxq) maxq = int'(bus.s_qos_i[i]);
`ifdef STREAM_QOS_SCHEDULER_AGING_EN
                if (mage[i] == AGE) prom = 1;
`endif
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.s_valid_i[i]) begin
                ok = prom ? (mage[i] == AGE) : (int'(bus.s_qos_i[i]) == maxq);
                d  = (i - mrr - 1 + 2 * N) % N;
                if (ok && d < bestd) begin best = i; bestd = d; end
            end
        end
        return best;
    endfunction

    task automatic mdl_step();
        int w;
        if (!mb) begin
            if (|bus.s_valid_i) begin
                w = mdl_pick();
`ifdef STREAM_QOS_SCHEDULER_AGING_EN
                for (int i = 0; i < N; i++) begin
                    if (i == w) mage[i] = 0;
                    else if (bus.s_valid_i[i] && mage[i] < AGE) mage[i]++;
                end
`endif
                mb = 1; mid = w; mqos = int'(bus.s_qos_i[w]); mrr = w;
            end
        end else if (bus.s_valid_i[mid] && bus.m_ready_i && bus.s_last_i[mid]) begin
            mb = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        bus.s_valid_i = '0;
        bus.s_last_i  = '0;
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.s_data_i[i] = '0;
            bus.s_qos_i[i]  = '0;
        end
    endtask

    task automatic set_src(input int i, input bit v, input int q, input bit l, input int d);
        bus.s_valid_i[i] = v;
        bus.s_qos_i[i]   = QW'(q);
        bus.s_last_i[i]  = l;
        bus.s_data_i[i]  = DW'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        for (int i = 0; i < N; i++) set_src(i, 1, 0, 1, 8'h10 + i);
        bus.m_ready_i = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #2;
        n_cmp++; if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid_o); end
        n_cmp++; if (bus.s_ready_o !== 3'b000) begin n_err++; $display("FAIL reset_s_ready got=%b exp=000", bus.s_ready_o); end
        n_cmp++; if (bus.m_id_o !== 2'd0) begin n_err++; $display("FAIL reset_m_id got=%0d exp=0", bus.m_id_o); end
        n_cmp++; if (bus.m_qos_o !== 4'd0) begin n_err++; $display("FAIL reset_m_qos got=%0d exp=0", bus.m_qos_o); end
        n_cmp++; if (bus.m_last_o !== 1'b0) begin n_err++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last_o); end
        n_cmp++; if (bus.m_data_o !== 8'h00) begin n_err++; $display("FAIL reset_m_data got=%h exp=00", bus.m_data_o); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_release_idle got=%b exp=0", bus.m_valid_o); end
        tick();
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b1) begin n_err++; $display("FAIL reset_first_grant_valid got=%b exp=1", bus.m_valid_o); end
        n_cmp++; if (bus.m_id_o !== 2'd0) begin n_err++; $display("FAIL reset_first_grant_id got=%0d exp=0", bus.m_id_o); end
    endtask

    task automatic test_qos_priority();
        apply_reset();
        set_src(0, 1, 3, 1, 8'hA0);
        set_src(1, 1, 9, 1, 8'hB1);
        bus.m_ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL qos_req_cycle_valid got=%b exp=0", bus.m_valid_o); end
        tick();
        #1;
        n_cmp++; if (bus.m_id_o !== 2'd1) begin n_err++; $display("FAIL qos_id got=%0d exp=1", bus.m_id_o); end
        n_cmp++; if (bus.m_qos_o !== 4'd9) begin n_err++; $display("FAIL qos_qos got=%0d exp=9", bus.m_qos_o); end
        n_cmp++; if (bus.m_valid_o !== 1'b1) begin n_err++; $display("FAIL qos_valid got=%b exp=1", bus.m_valid_o); end
        n_cmp++; if (bus.m_data_o !== 8'hB1) begin n_err++; $display("FAIL qos_data got=%h exp=b1", bus.m_data_o); end
        n_cmp++; if (bus.s_ready_o !== 3'b010) begin n_err++; $display("FAIL qos_s_ready got=%b exp=010", bus.s_ready_o); end
    endtask

    task automatic test_round_robin();
        int exp_id;
        apply_reset();
        set_src(0, 1, 5, 1, 8'h50);
        set_src(1, 1, 5, 1, 8'h51);
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            n_cmp++;
            if (bus.m_valid_o !== 1'(c % 2)) begin
                n_err++; $display("FAIL rr_valid cycle=%0d got=%b exp=%0d", c, bus.m_valid_o, c % 2);
            end
            if (c % 2 == 1) begin
                exp_id = (c / 2) % 2;
                n_cmp++;
                if (bus.m_id_o !== IW'(exp_id)) begin
                    n_err++; $display("FAIL rr_id cycle=%0d got=%0d exp=%0d", c, bus.m_id_o, exp_id);
                end
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        apply_reset();
        set_src(0, 1, 1, 0, 8'hD0);
        bus.m_ready_i = 1'b1;
        tick();                                    // grant s0
        #1;
        n_cmp++; if (bus.m_data_o !== 8'hD0) begin n_err++; $display("FAIL lock_beat1_data got=%h exp=d0", bus.m_data_o); end
        n_cmp++; if (bus.m_qos_o !== 4'd1) begin n_err++; $display("FAIL lock_qos got=%0d exp=1", bus.m_qos_o); end
        tick();
        set_src(0, 1, 7, 0, 8'hD1);                // beat 2, qos change ignored
        set_src(1, 1, 15, 1, 8'hE1);               // competing high-QoS request
        bus.m_ready_i = 1'b0;
        #1;
        n_cmp++; if (bus.m_data_o !== 8'hD1) begin n_err++; $display("FAIL lock_beat2_data got=%h exp=d1", bus.m_data_o); end
        n_cmp++; if (bus.s_ready_o !== 3'b000) begin n_err++; $display("FAIL lock_bp_ready got=%b exp=000", bus.s_ready_o); end
        n_cmp++; if (bus.m_qos_o !== 4'd1) begin n_err++; $display("FAIL lock_qos_held got=%0d exp=1", bus.m_qos_o); end
        tick();
        #1;
        n_cmp++; if (bus.m_data_o !== 8'hD1 || bus.m_id_o !== 2'd0 || bus.m_valid_o !== 1'b1) begin
            n_err++; $display("FAIL lock_bp_hold data=%h id=%0d valid=%b exp=d1/0/1", bus.m_data_o, bus.m_id_o, bus.m_valid_o);
        end
        tick();
        bus.m_ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.s_ready_o !== 3'b001) begin n_err++; $display("FAIL lock_release_ready got=%b exp=001", bus.s_ready_o); end
        tick();
        set_src(0, 1, 7, 1, 8'hD2);
        #1;
        n_cmp++; if (bus.m_last_o !== 1'b1 || bus.m_id_o !== 2'd0) begin
            n_err++; $display("FAIL lock_last last=%b id=%0d exp=1/0", bus.m_last_o, bus.m_id_o);
        end
        tick();
        set_src(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 3'b000) begin
            n_err++; $display("FAIL lock_gap valid=%b ready=%b exp=0/000", bus.m_valid_o, bus.s_ready_o);
        end
        tick();
        #1;
        n_cmp++; if (bus.m_id_o !== 2'd1 || bus.m_qos_o !== 4'd15 || bus.m_data_o !== 8'hE1) begin
            n_err++; $display("FAIL lock_next_grant id=%0d qos=%0d data=%h exp=1/15/e1", bus.m_id_o, bus.m_qos_o, bus.m_data_o);
        end
    endtask

    task automatic test_aging();
        int grants = 0;
        int exp_id;
        apply_reset();
        set_src(0, 1, 15, 1, 8'h0F);
        set_src(1, 1, 0, 1, 8'h10);
        bus.m_ready_i = 1'b1;
        for (int c = 0; c < 60 && grants < 20; c++) begin
            #1;
            if (bus.m_valid_o === 1'b1) begin
`ifdef STREAM_QOS_SCHEDULER_AGING_EN
                exp_id = (grants % 4 == 3) ? 1 : 0;
`else
                exp_id = 0;
`endif
                n_cmp++;
                if (bus.m_id_o !== IW'(exp_id)) begin
                    n_err++; $display("FAIL aging_grant n=%0d got=%0d exp=%0d", grants, bus.m_id_o, exp_id);
                end
                grants++;
            end
            tick();
        end
        n_cmp++;
        if (grants != 20) begin n_err++; $display("FAIL aging_grant_count got=%0d exp=20", grants); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_src(1, 1, 4, 0, 8'h20);
        bus.m_ready_i = 1'b1;
        tick();
        set_src(1, 1, 4, 0, 8'h21);
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b1 || bus.m_id_o !== 2'd1) begin
            n_err++; $display("FAIL arst_beat1 valid=%b id=%0d exp=1/1", bus.m_valid_o, bus.m_id_o);
        end
        tick();
        set_src(1, 1, 4, 0, 8'h22);
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b1) begin n_err++; $display("FAIL arst_beat2_valid got=%b exp=1", bus.m_valid_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b0 || bus.s_ready_o !== 3'b000) begin
            n_err++; $display("FAIL arst_same_cycle valid=%b ready=%b exp=0/000", bus.m_valid_o, bus.s_ready_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();
        drive_idle();
        set_src(1, 1, 6, 1, 8'h61);
        set_src(2, 1, 6, 1, 8'h62);
        bus.m_ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.m_valid_o !== 1'b0) begin n_err++; $display("FAIL arst_idle got=%b exp=0", bus.m_valid_o); end
        tick();
        #1;
        n_cmp++; if (bus.m_id_o !== 2'd1 || bus.m_valid_o !== 1'b1) begin
            n_err++; $display("FAIL arst_rr_restart id=%0d valid=%b exp=1/1", bus.m_id_o, bus.m_valid_o);
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    er;
        logic [DW-1:0]   ed;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                set_src(i, $urandom_range(0, 99) < 65, $urandom_range(0, 3),
                        $urandom_range(0, 2) == 0, $urandom_range(0, 255));
            bus.m_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            er = '0;
            if (mb && bus.m_ready_i) er[mid] = 1'b1;
            ed = mb ? bus.s_data_i[mid] : '0;
            n_cmp++;
            if (bus.m_valid_o !== (mb && bus.s_valid_i[mid])) begin
                n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.m_valid_o, mb && bus.s_valid_i[mid]);
            end
            n_cmp++;
            if (bus.m_data_o !== ed || bus.m_last_o !== (mb && bus.s_last_i[mid])) begin
                n_err++; $display("FAIL rand_data cyc=%0d got=%h/%b exp=%h/%b", c, bus.m_data_o, bus.m_last_o, ed, mb && bus.s_last_i[mid]);
            end
            n_cmp++;
            if (bus.s_ready_o !== er) begin
                n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.s_ready_o, er);
            end
            n_cmp++;
            if (bus.m_id_o !== IW'(mid) || bus.m_qos_o !== QW'(mqos)) begin
                n_err++; $display("FAIL rand_id_qos cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.m_id_o, bus.m_qos_o, mid, mqos);
            end
            mdl_step();
            tick();
        end
    endtask

    initial begin
        drive_idle();
        mdl_reset();
        test_reset();
        test_qos_priority();
        test_round_robin();
        test_packet_lock();
        test_aging();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end

endmodule
